// File: rtl/sdram_line_sched.sv
// Single-port SDRAM request scheduler: arbitrates refresh, capture-line writes and
// display-line reads, and owns the capture/display line pointers.
module sdram_line_sched #(
    parameter int LINE_W      = 9,
    parameter int LINES       = 288,
    parameter int LVL_W       = 10,
    parameter int FIFO_HI     = 768,
    parameter int REFR_CYCLES = 1040
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_fifo_nempty,
    input  logic [LVL_W-1:0]  i_fifo_level,
    input  logic              i_line_end,
    input  logic              i_cap_vsync,
    input  logic              i_disp_vsync,
    output logic              o_cmd_valid,
    output logic              o_cmd_write,
    output logic              o_cmd_refresh,
    output logic [LINE_W-1:0] o_cmd_line,
    input  logic              i_cmd_ack,
    input  logic              i_cmd_done,
    output logic              o_rd_overrun,
    output logic              o_busy
);

    localparam int                TMR_W     = $clog2(REFR_CYCLES);
    localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(REFR_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
    localparam logic [TMR_W-1:0]  TMR_ZERO  = TMR_W'(0);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES - 1);
    localparam logic [LINE_W-1:0] LINE_ONE  = LINE_W'(1);
    localparam logic [LINE_W-1:0] LINE_ZERO = LINE_W'(0);
    localparam logic [LVL_W-1:0]  LVL_HI    = LVL_W'(FIFO_HI);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    function automatic logic [LINE_W-1:0] next_line(input logic [LINE_W-1:0] cur);
        logic [LINE_W-1:0] nxt;
        if (cur == LINE_LAST) begin
            nxt = LINE_ZERO;
        end else begin
            nxt = cur + LINE_ONE;
        end
        return nxt;
    endfunction

    state_e              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                refr_pend_q, refr_pend_d;
    logic                le_s1_q, le_s1_d;
    logic                le_s2_q, le_s2_d;
    logic                rd_pend_q, rd_pend_d;
    logic                overrun_q, overrun_d;
    logic [LINE_W-1:0]   wr_line_q, wr_line_d;
    logic [LINE_W-1:0]   rd_line_q, rd_line_d;
    logic                wr_cancel_q, wr_cancel_d;
    logic                rd_cancel_q, rd_cancel_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic                cmd_write_q, cmd_write_d;
    logic                cmd_refresh_q, cmd_refresh_d;
    logic [LINE_W-1:0]   cmd_line_q, cmd_line_d;
    logic                busy_q, busy_d;

    logic                urgent_s;
    logic                req_any_s;
    logic                launch_s;
    logic                ack_s;
    logic                done_s;
    logic                ack_ref_s;
    logic                ack_rd_s;
    logic                edge_s;
    logic                tmr_hit_s;
    logic                wr_inflight_s;
    logic                rd_inflight_s;
    logic                wr_done_s;
    logic                rd_done_s;
    logic                sel_write_s;
    logic                sel_refresh_s;
    logic [LINE_W-1:0]   sel_line_s;

    // Handshake and request decode shared by the FSM and bookkeeping.
    always_comb begin
        urgent_s      = i_fifo_nempty && (i_fifo_level >= LVL_HI);
        req_any_s     = refr_pend_q || i_fifo_nempty || rd_pend_q;
        launch_s      = (state_q == ST_IDLE) && req_any_s;
        ack_s         = (state_q == ST_ISSUE) && i_cmd_ack;
        done_s        = ((state_q == ST_WAIT) && i_cmd_done) || (ack_s && i_cmd_done);
        ack_ref_s     = ack_s && cmd_refresh_q;
        ack_rd_s      = ack_s && !cmd_write_q && !cmd_refresh_q;
        wr_inflight_s = (state_q != ST_IDLE) && cmd_write_q;
        rd_inflight_s = (state_q != ST_IDLE) && !cmd_write_q && !cmd_refresh_q;
        wr_done_s     = done_s && cmd_write_q;
        rd_done_s     = done_s && !cmd_write_q && !cmd_refresh_q;
        edge_s        = le_s1_q && !le_s2_q;
        tmr_hit_s     = (tmr_q == TMR_ONE);
    end

    // Fixed-priority selection; a vsync on the launch cycle already means line 0.
    always_comb begin
        sel_write_s   = 1'b0;
        sel_refresh_s = 1'b0;
        sel_line_s    = LINE_ZERO;
        if (refr_pend_q) begin
            sel_refresh_s = 1'b1;
        end else if (urgent_s) begin
            sel_write_s = 1'b1;
            sel_line_s  = i_cap_vsync ? LINE_ZERO : wr_line_q;
        end else if (rd_pend_q) begin
            sel_line_s  = i_disp_vsync ? LINE_ZERO : rd_line_q;
        end else if (i_fifo_nempty) begin
            sel_write_s = 1'b1;
            sel_line_s  = i_cap_vsync ? LINE_ZERO : wr_line_q;
        end else begin
            sel_line_s  = LINE_ZERO;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (ack_s) begin
                    state_d = i_cmd_done ? ST_IDLE : ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (i_cmd_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: command fields latched at launch and held for the whole operation.
    always_comb begin
        cmd_valid_d = (state_d == ST_ISSUE);
        busy_d      = (state_d != ST_IDLE);
        if (launch_s) begin
            cmd_write_d   = sel_write_s;
            cmd_refresh_d = sel_refresh_s;
            cmd_line_d    = sel_line_s;
        end else begin
            cmd_write_d   = cmd_write_q;
            cmd_refresh_d = cmd_refresh_q;
            cmd_line_d    = cmd_line_q;
        end
    end

    // Refresh timer, pending flags, line-end edge detect and line pointers.
    always_comb begin
        tmr_d = (tmr_q == TMR_ZERO) ? TMR_LOAD : (tmr_q - TMR_ONE);

        if (ack_ref_s) begin
            refr_pend_d = 1'b0;
        end else if (tmr_hit_s) begin
            refr_pend_d = 1'b1;
        end else begin
            refr_pend_d = refr_pend_q;
        end

        le_s1_d = i_line_end;
        le_s2_d = le_s1_q;

        // A new edge on the ack cycle is a fresh request, not a lost one.
        if (edge_s) begin
            rd_pend_d = 1'b1;
        end else if (ack_rd_s) begin
            rd_pend_d = 1'b0;
        end else begin
            rd_pend_d = rd_pend_q;
        end
        overrun_d = edge_s && rd_pend_q && !ack_rd_s;

        if (launch_s) begin
            wr_cancel_d = 1'b0;
        end else if (i_cap_vsync && wr_inflight_s) begin
            wr_cancel_d = 1'b1;
        end else begin
            wr_cancel_d = wr_cancel_q;
        end

        if (launch_s) begin
            rd_cancel_d = 1'b0;
        end else if (i_disp_vsync && rd_inflight_s) begin
            rd_cancel_d = 1'b1;
        end else begin
            rd_cancel_d = rd_cancel_q;
        end

        if (i_cap_vsync) begin
            wr_line_d = LINE_ZERO;
        end else if (wr_done_s && !wr_cancel_q) begin
            wr_line_d = next_line(wr_line_q);
        end else begin
            wr_line_d = wr_line_q;
        end

        if (i_disp_vsync) begin
            rd_line_d = LINE_ZERO;
        end else if (rd_done_s && !rd_cancel_q) begin
            rd_line_d = next_line(rd_line_q);
        end else begin
            rd_line_d = rd_line_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tmr_q         <= TMR_LOAD;
            refr_pend_q   <= 1'b0;
            le_s1_q       <= 1'b0;
            le_s2_q       <= 1'b0;
            rd_pend_q     <= 1'b0;
            overrun_q     <= 1'b0;
            wr_line_q     <= LINE_ZERO;
            rd_line_q     <= LINE_ZERO;
            wr_cancel_q   <= 1'b0;
            rd_cancel_q   <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_write_q   <= 1'b0;
            cmd_refresh_q <= 1'b0;
            cmd_line_q    <= LINE_ZERO;
            busy_q        <= 1'b0;
        end else begin
            tmr_q         <= tmr_d;
            refr_pend_q   <= refr_pend_d;
            le_s1_q       <= le_s1_d;
            le_s2_q       <= le_s2_d;
            rd_pend_q     <= rd_pend_d;
            overrun_q     <= overrun_d;
            wr_line_q     <= wr_line_d;
            rd_line_q     <= rd_line_d;
            wr_cancel_q   <= wr_cancel_d;
            rd_cancel_q   <= rd_cancel_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_write_q   <= cmd_write_d;
            cmd_refresh_q <= cmd_refresh_d;
            cmd_line_q    <= cmd_line_d;
            busy_q        <= busy_d;
        end
    end

    assign o_cmd_valid   = cmd_valid_q;
    assign o_cmd_write   = cmd_write_q;
    assign o_cmd_refresh = cmd_refresh_q;
    assign o_cmd_line    = cmd_line_q;
    assign o_rd_overrun  = overrun_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_sdram_line_sched.sv
// Directed bench for sdram_line_sched: refresh cadence, arbitration order,
// pointer wrap and vsync restart, read overrun, asynchronous reset.
module tb_sdram_line_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_nempty = 1'b0;
    logic [9:0] fifo_level = 10'd0;
    logic       line_end = 1'b0;
    logic       cap_vsync = 1'b0;
    logic       disp_vsync = 1'b0;
    logic       cmd_valid;
    logic       cmd_write;
    logic       cmd_refresh;
    logic [8:0] cmd_line;
    logic       cmd_ack = 1'b0;
    logic       cmd_done = 1'b0;
    logic       rd_overrun;
    logic       busy;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    sdram_line_sched dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_fifo_nempty (fifo_nempty),
        .i_fifo_level  (fifo_level),
        .i_line_end    (line_end),
        .i_cap_vsync   (cap_vsync),
        .i_disp_vsync  (disp_vsync),
        .o_cmd_valid   (cmd_valid),
        .o_cmd_write   (cmd_write),
        .o_cmd_refresh (cmd_refresh),
        .o_cmd_line    (cmd_line),
        .i_cmd_ack     (cmd_ack),
        .i_cmd_done    (cmd_done),
        .o_rd_overrun  (rd_overrun),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_until(input int n, input string tag);
        int hits = 0;
        while (cyc < n) begin
            step();
            if (cmd_valid) hits++;
        end
        check(tag, hits, 0);
    endtask

    task automatic wait_cmd(output logic r, output logic w, output logic [8:0] l);
        int t = 0;
        while (!cmd_valid && t < 40) begin
            step();
            t++;
        end
        check("cmd_seen", {31'd0, cmd_valid}, 1);
        r = cmd_refresh;
        w = cmd_write;
        l = cmd_line;
    endtask

    task automatic ack_cmd();
        cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b0;
    endtask

    task automatic done_cmd();
        cmd_done = 1'b1;
        step();
        cmd_done = 1'b0;
    endtask

    // Waits for the next write, servicing any refresh that gets in first.
    task automatic next_write(output logic [8:0] l);
        logic r;
        logic w;
        int   k = 0;
        do begin
            wait_cmd(r, w, l);
            if (r) begin
                ack_cmd();
                done_cmd();
            end
            k++;
        end while (r && k < 4);
        check("write_flag", {31'd0, w}, 1);
    endtask

    initial begin
        logic       r;
        logic       w;
        logic [8:0] l;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",   {31'd0, cmd_valid},   0);
        check("rst_write",   {31'd0, cmd_write},   0);
        check("rst_refresh", {31'd0, cmd_refresh}, 0);
        check("rst_line",    {23'd0, cmd_line},    0);
        check("rst_overrun", {31'd0, rd_overrun},  0);
        check("rst_busy",    {31'd0, busy},        0);

        // Refresh cadence after reset release.
        rst_n = 1'b1;
        cyc   = 0;
        idle_until(1039, "refr1_quiet");
        step();
        check("refr1_valid",   {31'd0, cmd_valid},   1);
        check("refr1_refresh", {31'd0, cmd_refresh}, 1);
        check("refr1_write",   {31'd0, cmd_write},   0);
        check("refr1_line",    {23'd0, cmd_line},    0);
        ack_cmd();
        check("refr1_ack_valid", {31'd0, cmd_valid}, 0);
        check("refr1_ack_busy",  {31'd0, busy},      1);
        done_cmd();
        check("refr1_done_busy", {31'd0, busy}, 0);
        idle_until(2079, "refr2_quiet");
        step();
        check("refr2_valid",   {31'd0, cmd_valid},   1);
        check("refr2_refresh", {31'd0, cmd_refresh}, 1);
        cmd_ack  = 1'b1;
        cmd_done = 1'b1;
        step();
        cmd_ack  = 1'b0;
        cmd_done = 1'b0;
        check("refr2_ackdone_valid", {31'd0, cmd_valid}, 0);
        check("refr2_ackdone_busy",  {31'd0, busy},      0);

        // Read pending and non-urgent write: read wins.
        line_end = 1'b1;
        step();
        step();
        fifo_nempty = 1'b1;
        fifo_level  = 10'd100;
        wait_cmd(r, w, l);
        check("t2_first_read", {31'd0, w}, 0);
        check("t2_read_line",  {23'd0, l}, 0);
        ack_cmd();
        done_cmd();
        line_end = 1'b0;
        wait_cmd(r, w, l);
        check("t2_second_write", {31'd0, w}, 1);
        check("t2_write_line",   {23'd0, l}, 0);
        ack_cmd();
        fifo_nempty = 1'b0;
        done_cmd();

        // Read pending and urgent write: write wins; both pointers now 1.
        line_end = 1'b1;
        step();
        step();
        fifo_nempty = 1'b1;
        fifo_level  = 10'd800;
        wait_cmd(r, w, l);
        check("t3_first_write", {31'd0, w}, 1);
        check("t3_write_line",  {23'd0, l}, 1);
        ack_cmd();
        fifo_nempty = 1'b0;
        fifo_level  = 10'd0;
        done_cmd();
        wait_cmd(r, w, l);
        check("t3_second_read", {31'd0, w}, 0);
        check("t3_read_line",   {23'd0, l}, 1);
        ack_cmd();
        done_cmd();
        line_end = 1'b0;

        // Second line-end edge while the read is withheld: one overrun pulse.
        step();
        step();
        line_end = 1'b1;
        step();
        step();
        wait_cmd(r, w, l);
        check("t5_read", {31'd0, w}, 0);
        check("t5_read_line", {23'd0, l}, 2);
        line_end = 1'b0;
        step();
        step();
        step();
        line_end = 1'b1;
        step();
        check("t5_overrun_pre", {31'd0, rd_overrun}, 0);
        step();
        check("t5_overrun_pulse", {31'd0, rd_overrun}, 1);
        step();
        check("t5_overrun_post", {31'd0, rd_overrun}, 0);
        check("t5_still_valid", {31'd0, cmd_valid}, 1);
        ack_cmd();
        done_cmd();
        line_end = 1'b0;
        idle_until(cyc + 10, "t5_single_read");

        // 289 writes: lines 0..287 then wrap to 0.
        cap_vsync = 1'b1;
        step();
        cap_vsync   = 1'b0;
        fifo_nempty = 1'b1;
        fifo_level  = 10'd100;
        for (int i = 0; i <= 288; i++) begin
            next_write(l);
            check("wrap_line", {23'd0, l}, (i == 288) ? 0 : i);
            ack_cmd();
            done_cmd();
        end
        for (int i = 1; i <= 5; i++) begin
            next_write(l);
            check("pre_vsync_line", {23'd0, l}, i);
            ack_cmd();
            if (i == 5) begin
                cap_vsync = 1'b1;
                step();
                cap_vsync = 1'b0;
            end
            done_cmd();
        end
        next_write(l);
        check("vsync_restart_line", {23'd0, l}, 0);
        ack_cmd();
        done_cmd();

        // Asynchronous reset while a write is in WAIT.
        next_write(l);
        check("t6_line", {23'd0, l}, 1);
        ack_cmd();
        check("t6_busy_wait", {31'd0, busy}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", {31'd0, cmd_valid}, 0);
        check("t6_async_busy",  {31'd0, busy},      0);
        check("t6_async_write", {31'd0, cmd_write}, 0);
        check("t6_async_line",  {23'd0, cmd_line},  0);
        fifo_nempty = 1'b0;
        fifo_level  = 10'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        idle_until(1039, "t6_refr_quiet");
        step();
        check("t6_refr_valid",   {31'd0, cmd_valid},   1);
        check("t6_refr_refresh", {31'd0, cmd_refresh}, 1);
        ack_cmd();
        done_cmd();
        line_end = 1'b1;
        step();
        step();
        wait_cmd(r, w, l);
        check("t6_read",      {31'd0, w}, 0);
        check("t6_read_line", {23'd0, l}, 0);
        ack_cmd();
        done_cmd();
        line_end    = 1'b0;
        fifo_nempty = 1'b1;
        wait_cmd(r, w, l);
        check("t6_write",      {31'd0, w}, 1);
        check("t6_write_line", {23'd0, l}, 0);
        ack_cmd();
        fifo_nempty = 1'b0;
        done_cmd();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sdram_line_sched.md
# sdram_line_sched

Request scheduler in front of the single-port SDRAM line controller. Arbitrates three requesters for the one SDRAM command port: periodic refresh, capture-line writes drained from the capture FIFO, and display-line reads triggered at display line end. Owns the capture and display line pointers and their wrap at frame size. Issues one operation at a time over a valid/ack/done handshake.

## Interface
Parameters:
- `LINE_W`, 9: line index width.
- `LINES`, 288: lines per frame; pointers wrap at `LINES-1`.
- `LVL_W`, 10: capture FIFO level width.
- `FIFO_HI`, 768: FIFO level at or above which a write is urgent.
- `REFR_CYCLES`, 1040: clocks between refresh requests.

Ports:
- `i_clk` in 1: single clock.
- `i_reset_n` in 1: **reset is asynchronous, active-low**; all state is cleared immediately on assertion.
- `i_fifo_nempty` in 1: capture FIFO holds at least one complete line.
- `i_fifo_level` in `LVL_W`: capture FIFO word count.
- `i_line_end` in 1: display line-end level, synchronous to `i_clk`.
- `i_cap_vsync` in 1: one-cycle pulse at capture frame start.
- `i_disp_vsync` in 1: one-cycle pulse at display frame start.
- `o_cmd_valid` out 1: command presented.
- `o_cmd_write` out 1: 1 = write line, 0 = read line. Valid with `o_cmd_valid`.
- `o_cmd_refresh` out 1: refresh command. `o_cmd_write` is 0 when this is set.
- `o_cmd_line` out `LINE_W`: SDRAM row/line for read or write. 0 for refresh.
- `i_cmd_ack` in 1: controller accepted the command.
- `i_cmd_done` in 1: one-cycle pulse; the accepted operation has finished, including precharge.
- `o_rd_overrun` out 1: one-cycle pulse; a display request was lost.
- `o_busy` out 1: state is not IDLE.

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: `o_cmd_valid`=1, fields held stable until `i_cmd_ack`.
  - WAIT: wait for `i_cmd_done`.
- Transitions:
  - IDLE→ISSUE when any request is pending.
  - ISSUE→WAIT on ack without done.
  - ISSUE→IDLE on ack and done in the same cycle.
  - WAIT→IDLE on done.
  - `i_cmd_done` outside WAIT/ISSUE is ignored.
- Priority is evaluated in IDLE only, highest first:
  1. `refr_pend`.
  2. Urgent write: `i_fifo_nempty` && `i_fifo_level >= FIFO_HI`.
  3. `rd_pend`.
  4. Write: `i_fifo_nempty`.
- Refresh timer: loads `REFR_CYCLES-1` at reset and on expiry, then counts down.
  - Reaching 0 sets `refr_pend`.
  - Expiry while `refr_pend` is already set does not queue a second refresh.
  - `refr_pend` clears on ack of a refresh.
- Read request:
  - The rising edge of `i_line_end` (registered once, compared against the previous sample) sets `rd_pend`.
  - An edge while `rd_pend`=1 pulses `o_rd_overrun` and leaves `rd_pend` set.
  - `rd_pend` clears on ack of a read.
  - Edge and ack in the same cycle: `rd_pend` stays 1 (new request) and there is no overrun.
- Pointers `wr_line`, `rd_line` (`LINE_W` bits):
  - `o_cmd_line` = `wr_line` for writes, `rd_line` for reads, latched at IDLE→ISSUE.
  - On done of a write, `wr_line` advances; on done of a read, `rd_line` advances. The value `LINES-1` wraps to 0.
  - `i_cap_vsync` forces `wr_line`=0. If a write is in flight, its done does not advance the pointer. Same rule for `i_disp_vsync`/`rd_line`.
  - vsync has priority over a simultaneous done.
- Reset mid-operation: drops `o_cmd_valid` immediately, clears all pending flags and pointers, and reloads the timer. The controller is reset by the same signal.

## Timing
- Reset values: `o_cmd_valid`, `o_cmd_write`, `o_cmd_refresh`, `o_cmd_line`, `o_rd_overrun`, `o_busy` all 0.
- All outputs are registered.
- Request visible in IDLE at cycle N → `o_cmd_valid`=1 at N+1.
- Ack at cycle M → `o_cmd_valid`=0 at M+1.
- Done at cycle D → IDLE at D+1; next `o_cmd_valid` at D+2 at the earliest.
- Line-end edge to `rd_pend`: 2 cycles (input register plus edge detect).
- `o_rd_overrun` is asserted exactly one cycle per lost edge.

## Test plan
- Reset, then idle for `REFR_CYCLES`: exactly one `o_cmd_refresh` at cycle 1040 after reset release, `o_cmd_line`=0. Ack and done it; the next refresh comes 1040 cycles after the previous expiry.
- `i_fifo_nempty`=1, level 100, `i_line_end` edge in the same cycle: read issued first with line 0, then write with line 0. After both dones, `rd_line`=1 and `wr_line`=1.
- Same as above with level 800: write is issued before the read.
- Drive 288 write completions: `o_cmd_line` runs 0..287, then wraps to 0. Assert `i_cap_vsync` during write 5 (line 5 in flight): the next write uses line 0.
- Second `i_line_end` edge while a read is still pending (controller withholding ack): one `o_rd_overrun` pulse, and only one read is issued.
- Assert `i_reset_n`=0 asynchronously while in WAIT: `o_cmd_valid`/`o_busy` drop without a clock edge. After release, pointers are 0 and the first refresh again comes at 1040.
